// File: rtl/fpga_config_loader.sv
// -----------------------------------------------------------------------------
// fpga_config_loader
//
// Configuration controller for the 2x2-CLB fabric. The bitstream arrives as
// DATA_W-bit words over a valid/ready stream, MSB-first. An XOR checksum word
// follows the image words. All fabric config vectors are updated together in
// one clock edge, and only after the checksum has matched. The fabric is held
// in reset while a load is in progress and after a failed load.
//
// Ports
//   clk                   rising-edge clock
//   reset                 synchronous, active-high reset
//   cfg_start             pulse: begin or restart a load
//   cfg_data [DATA_W]     bitstream word
//   cfg_valid             cfg_data is valid
//   cfg_ready             loader accepts a word this cycle (decoded from state)
//   BLE_dff_select [9]    committed config
//   IO_sel [4]            committed config
//   LUT_in [144]          committed config
//   SB_in [240]           committed config
//   CB_in [420]           committed config
//   sel_direction_BLEout [36]  committed config
//   sel_direction [18]    committed config
//   fabric_reset          reset to the fabric, high while not configured
//   cfg_done              last load committed OK (level)
//   cfg_err               last load failed its checksum (level)
//   busy                  loader is not idle
// -----------------------------------------------------------------------------
module fpga_config_loader #(
    parameter int DATA_W = 16,
    parameter int CFG_W  = 871
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [8:0]        BLE_dff_select,
    output logic [3:0]        IO_sel,
    output logic [143:0]      LUT_in,
    output logic [239:0]      SB_in,
    output logic [419:0]      CB_in,
    output logic [35:0]       sel_direction_BLEout,
    output logic [17:0]       sel_direction,
    output logic              fabric_reset,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy
);

    localparam int NWORDS = (CFG_W + DATA_W - 1) / DATA_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    // Bit offsets of each field inside the packed image (LSB field first).
    localparam int SD_LO   = 0;
    localparam int SDB_LO  = SD_LO + 18;
    localparam int CB_LO   = SDB_LO + 36;
    localparam int SB_LO   = CB_LO + 420;
    localparam int LUT_LO  = SB_LO + 240;
    localparam int IO_LO   = LUT_LO + 144;
    localparam int BLE_LO  = IO_LO + 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    logic [2:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] acc_r;
    // Only the low CFG_W bits of the shifted stream are kept, so the pad bits
    // carried on top of word 0 fall off the end by the time loading finishes.
    logic [CFG_W-1:0]  shadow_r;
    logic              accept_s;

    // Running XOR checksum step.
    function automatic logic [DATA_W-1:0] xor_fold(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] word);
        return acc ^ word;
    endfunction

    // Ready and busy are pure decodes of the registered state.
    always_comb begin
        cfg_ready = 1'b0;
        case (state_r)
            ST_LOAD, ST_CHECK: cfg_ready = 1'b1;
            default:           cfg_ready = 1'b0;
        endcase
    end

    assign busy     = (state_r != ST_IDLE);
    assign accept_s = cfg_valid & cfg_ready;

    // Loader FSM, shadow image, checksum and committed outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r              <= ST_IDLE;
            cnt_r                <= '0;
            acc_r                <= '0;
            shadow_r             <= '0;
            BLE_dff_select       <= 9'd0;
            IO_sel               <= 4'd0;
            LUT_in               <= 144'd0;
            SB_in                <= 240'd0;
            CB_in                <= 420'd0;
            sel_direction_BLEout <= 36'd0;
            sel_direction        <= 18'd0;
            fabric_reset         <= 1'b1;
            cfg_done             <= 1'b0;
            cfg_err              <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_LOAD, ST_CHECK: begin
                    if (cfg_start) begin
                        // Start or restart: any word presented alongside is dropped.
                        state_r      <= ST_LOAD;
                        cnt_r        <= '0;
                        acc_r        <= '0;
                        shadow_r     <= '0;
                        cfg_done     <= 1'b0;
                        cfg_err      <= 1'b0;
                        fabric_reset <= 1'b1;
                    end else if (accept_s && (state_r == ST_LOAD)) begin
                        shadow_r <= {shadow_r[CFG_W-DATA_W-1:0], cfg_data};
                        acc_r    <= xor_fold(acc_r, cfg_data);
                        cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_CNT) begin
                            state_r <= ST_CHECK;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else if (accept_s && (state_r == ST_CHECK)) begin
                        if (cfg_data == acc_r) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            state_r <= ST_ERROR;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_COMMIT: begin
                    // Every field and the fabric reset release share this edge.
                    BLE_dff_select       <= shadow_r[BLE_LO +: 9];
                    IO_sel               <= shadow_r[IO_LO +: 4];
                    LUT_in               <= shadow_r[LUT_LO +: 144];
                    SB_in                <= shadow_r[SB_LO +: 240];
                    CB_in                <= shadow_r[CB_LO +: 420];
                    sel_direction_BLEout <= shadow_r[SDB_LO +: 36];
                    sel_direction        <= shadow_r[SD_LO +: 18];
                    cfg_done             <= 1'b1;
                    fabric_reset         <= 1'b0;
                    state_r              <= ST_IDLE;
                end
                ST_ERROR: begin
                    cfg_err <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
